// File: rtl/tt_seq_pkg.sv
// Shared definitions for the add sequencer: FSM state encoding, the 2-bit
// opcode values carried on uio_in[2:1], and the bit positions used when
// decoding uio_in and assembling uio_out.
package tt_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GET_B  = 2'd1,
    ST_EXEC   = 2'd2,
    ST_RESULT = 2'd3
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_NOT = 2'b10;
  localparam logic [1:0] OP_ACC = 2'b11;

  // uio_in control bits
  localparam int UIO_IN_VALID = 0;
  localparam int UIO_OP_LSB   = 1;
  localparam int UIO_OP_MSB   = 2;
  localparam int UIO_RES_ACK  = 3;

  // uio_out status bits
  localparam int UIO_IN_READY  = 4;
  localparam int UIO_RES_VALID = 5;
  localparam int UIO_CARRY     = 6;
  localparam int UIO_BUSY      = 7;

  localparam logic [7:0] UIO_OE_MASK = 8'hF0;

endpackage

// File: rtl/tt_alu_core.sv
// Combinational arithmetic core for the add sequencer.
// Ports:
//   op     - 2-bit opcode (ADD, SUB, NOT, ACC)
//   a, b   - captured operands
//   acc    - current accumulator value
//   result - low 8 bits of the operation
//   carry  - adder bit 8 for ADD/ACC, no-borrow flag for SUB, 0 for NOT
module tt_alu_core
  import tt_seq_pkg::*;
(
  input  logic [1:0] op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [7:0] acc,
  output logic [7:0] result,
  output logic       carry
);

  logic [7:0] opnd_x;
  logic [7:0] opnd_y;
  logic       carry_in;
  logic [8:0] sum;

  // One 9-bit adder serves every arithmetic op; only the operand muxes
  // change. SUB is done as A + ~B + 1, so bit 8 reads as "no borrow".
  always_comb begin
    opnd_x   = a;
    opnd_y   = b;
    carry_in = 1'b0;
    case (op)
      OP_SUB: begin
        opnd_y   = ~b;
        carry_in = 1'b1;
      end
      OP_ACC: begin
        opnd_x = acc;
        opnd_y = a;
      end
      default: ;
    endcase
  end

  assign sum = {1'b0, opnd_x} + {1'b0, opnd_y} + {8'd0, carry_in};

  // NOT skips the adder entirely and never reports a carry.
  always_comb begin
    result = sum[7:0];
    carry  = sum[8];
    if (op == OP_NOT) begin
      result = ~a;
      carry  = 1'b0;
    end
  end

endmodule

// File: rtl/tt_add_sequencer.sv
// Byte-serial add/sub/not/accumulate sequencer.
// Operand A (and B for ADD/SUB) arrive on ui_in under an in_valid handshake;
// the result is presented on uo_out with carry until res_ack.
// Ports:
//   clk, rst_n - clock and asynchronous active-low reset
//   ena        - global enable; low freezes everything
//   ui_in      - operand byte
//   uio_in     - [0] in_valid, [2:1] op, [3] res_ack
//   uo_out     - result register
//   uio_out    - [4] in_ready, [5] res_valid, [6] carry, [7] busy
//   uio_oe     - constant 8'hF0 (upper nibble driven)
module tt_add_sequencer
  import tt_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  state_t     state;
  state_t     state_next;
  logic [7:0] a_reg;
  logic [7:0] b_reg;
  logic [7:0] acc_reg;
  logic [7:0] result_reg;
  logic [1:0] op_reg;
  logic       carry_reg;
  logic       capture_a;
  logic       capture_b;
  logic       do_exec;
  logic       in_valid;
  logic       res_ack;
  logic [1:0] op_in;
  logic [7:0] alu_result;
  logic       alu_carry;
  logic       unused_uio_in;

  assign in_valid      = uio_in[UIO_IN_VALID];
  assign op_in         = uio_in[UIO_OP_MSB:UIO_OP_LSB];
  assign res_ack       = uio_in[UIO_RES_ACK];
  assign unused_uio_in = ^uio_in[7:4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else if (ena) begin
      state <= state_next;
    end
  end

  // Next-state plus the one-cycle load strobes for the datapath registers.
  // The opcode is only taken in IDLE, so GET_B ignores uio_in[2:1].
  always_comb begin
    state_next = state;
    capture_a  = 1'b0;
    capture_b  = 1'b0;
    do_exec    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          capture_a = 1'b1;
          if ((op_in == OP_ADD) || (op_in == OP_SUB)) begin
            state_next = ST_GET_B;
          end else begin
            state_next = ST_EXEC;
          end
        end
      end
      ST_GET_B: begin
        if (in_valid) begin
          capture_b  = 1'b1;
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        do_exec    = 1'b1;
        state_next = ST_RESULT;
      end
      ST_RESULT: begin
        if (res_ack) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  tt_alu_core u_alu (
    .op     (op_reg),
    .a      (a_reg),
    .b      (b_reg),
    .acc    (acc_reg),
    .result (alu_result),
    .carry  (alu_carry)
  );

  // Operand, accumulator and result registers. The result and carry only
  // change in EXEC, so they stay put through RESULT and back in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg      <= 8'h00;
      b_reg      <= 8'h00;
      acc_reg    <= 8'h00;
      result_reg <= 8'h00;
      op_reg     <= OP_ADD;
      carry_reg  <= 1'b0;
    end else if (ena) begin
      if (capture_a) begin
        a_reg  <= ui_in;
        op_reg <= op_in;
      end
      if (capture_b) begin
        b_reg <= ui_in;
      end
      if (do_exec) begin
        result_reg <= alu_result;
        carry_reg  <= alu_carry;
        if (op_reg == OP_ACC) begin
          acc_reg <= alu_result;
        end
      end
    end
  end

  assign uo_out = result_reg;
  assign uio_oe = UIO_OE_MASK;

  always_comb begin
    uio_out                = 8'h00;
    uio_out[UIO_IN_READY]  = (state == ST_IDLE) || (state == ST_GET_B);
    uio_out[UIO_RES_VALID] = (state == ST_RESULT);
    uio_out[UIO_CARRY]     = carry_reg;
    uio_out[UIO_BUSY]      = (state != ST_IDLE);
  end

endmodule

// File: tb/tb_tt_add_sequencer.sv
// Self-checking bench for tt_add_sequencer. Expected results come from a
// small behavioural model, are queued when an operation is issued and are
// popped when the design raises res_valid.
module tb_tt_add_sequencer;

  localparam logic [1:0] T_ADD = 2'b00;
  localparam logic [1:0] T_SUB = 2'b01;
  localparam logic [1:0] T_NOT = 2'b10;
  localparam logic [1:0] T_ACC = 2'b11;

  typedef struct {
    logic [7:0] res;
    logic       carry;
    string      tag;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] acc_model = 8'h00;
  exp_t       sb[$];

  tt_add_sequencer dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_value(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer arithmetic, independent of the adder trick.
  task automatic push_expected(input logic [1:0] op, input logic [7:0] a,
                               input logic [7:0] b, input string tag);
    exp_t e;
    int   s;
    e.tag = tag;
    case (op)
      T_ADD: begin
        s       = int'(a) + int'(b);
        e.res   = 8'(s % 256);
        e.carry = (s > 255);
      end
      T_SUB: begin
        e.res   = 8'((int'(a) - int'(b) + 256) % 256);
        e.carry = (a >= b);
      end
      T_NOT: begin
        e.res   = ~a;
        e.carry = 1'b0;
      end
      default: begin
        s         = int'(acc_model) + int'(a);
        e.res     = 8'(s % 256);
        e.carry   = (s > 255);
        acc_model = e.res;
      end
    endcase
    sb.push_back(e);
  endtask

  // Issue one operation and check the handshake and two-cycle latency.
  // Returns in the first RESULT cycle. During B the op field is driven as
  // NOT, which must have no effect.
  task automatic apply_stimulus(input logic [1:0] op, input logic [7:0] a,
                                input logic [7:0] b, input string tag);
    int n = 0;
    while (uio_out[4] !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    check_value({tag, " in_ready"}, {7'd0, uio_out[4]}, 8'h01);
    ui_in  = a;
    uio_in = {4'b0000, 1'b0, op, 1'b1};
    tick();
    if (op == T_ADD || op == T_SUB) begin
      check_value({tag, " get_b status"}, uio_out & 8'hB0, 8'h90);
      ui_in  = b;
      uio_in = 8'b0000_0101;
      tick();
    end
    uio_in = 8'h00;
    ui_in  = 8'h00;
    push_expected(op, a, b, tag);
    check_value({tag, " exec status"}, uio_out & 8'hB0, 8'h80);
    tick();
    check_value({tag, " latency"}, uio_out & 8'hB0, 8'hA0);
  endtask

  // Wait for res_valid, compare against the scoreboard, acknowledge and
  // confirm the result is retained back in IDLE.
  task automatic check_output();
    exp_t e;
    int   n = 0;
    while (uio_out[5] !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL scoreboard observed=empty expected=entry");
      return;
    end
    e = sb.pop_front();
    check_value({e.tag, " res_valid"}, {7'd0, uio_out[5]}, 8'h01);
    check_value({e.tag, " result"}, uo_out, e.res);
    check_value({e.tag, " carry"}, {7'd0, uio_out[6]}, {7'd0, e.carry});
    uio_in = 8'h08;
    tick();
    uio_in = 8'h00;
    check_value({e.tag, " idle status"}, uio_out, {1'b0, e.carry, 1'b0, 1'b1, 4'b0000});
    check_value({e.tag, " retained"}, uo_out, e.res);
  endtask

  initial begin
    $display("[TB] start");

    // Reset state
    #1;
    check_value("reset uo_out", uo_out, 8'h00);
    check_value("reset uio_out", uio_out, 8'h10);
    check_value("reset uio_oe", uio_oe, 8'hF0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check_value("post reset status", uio_out, 8'h10);
    check_value("post reset uio_oe", uio_oe, 8'hF0);

    // Basic arithmetic
    apply_stimulus(T_ADD, 8'h12, 8'h34, "add_12_34");
    check_output();
    apply_stimulus(T_ADD, 8'hFF, 8'h01, "add_ff_01");
    check_output();
    apply_stimulus(T_SUB, 8'h10, 8'h20, "sub_10_20");
    check_output();
    apply_stimulus(T_SUB, 8'h20, 8'h10, "sub_20_10");
    check_output();
    apply_stimulus(T_NOT, 8'hA5, 8'h00, "not_a5");
    check_output();

    // Accumulator, and an ADD in between must not disturb it
    apply_stimulus(T_ACC, 8'h80, 8'h00, "acc_80");
    check_output();
    apply_stimulus(T_ACC, 8'h90, 8'h00, "acc_90");
    check_output();
    apply_stimulus(T_ADD, 8'h03, 8'h04, "add_03_04");
    check_output();
    apply_stimulus(T_ACC, 8'h00, 8'h00, "acc_00");
    check_output();

    // in_valid held high through RESULT, late acknowledge
    apply_stimulus(T_ADD, 8'h01, 8'h01, "hold_valid");
    ui_in  = 8'h77;
    uio_in = 8'h01;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_value("hold res_valid", uio_out & 8'hB0, 8'hA0);
      check_value("hold uo_out", uo_out, 8'h02);
    end
    check_output();
    ui_in = 8'h00;

    // ena low while waiting in GET_B
    ui_in  = 8'h20;
    uio_in = 8'h01;
    tick();
    check_value("ena get_b status", uio_out & 8'hB0, 8'h90);
    ena    = 1'b0;
    ui_in  = 8'h07;
    uio_in = 8'h09;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_value("frozen status", uio_out, 8'h90);
      check_value("frozen uo_out", uo_out, 8'h02);
    end
    ena    = 1'b1;
    ui_in  = 8'h05;
    uio_in = 8'h01;
    tick();
    uio_in = 8'h00;
    push_expected(T_ADD, 8'h20, 8'h05, "ena_add_20_05");
    tick();
    check_output();

    // Reset in the middle of an operation
    ui_in  = 8'h33;
    uio_in = 8'h01;
    tick();
    uio_in = 8'h00;
    check_value("pre reset get_b", uio_out & 8'hB0, 8'h90);
    rst_n = 1'b0;
    #1;
    check_value("mid reset uo_out", uo_out, 8'h00);
    check_value("mid reset uio_out", uio_out, 8'h10);
    acc_model = 8'h00;
    tick();
    rst_n = 1'b1;
    tick();
    check_value("after reset idle", uio_out, 8'h10);
    apply_stimulus(T_ACC, 8'h05, 8'h00, "acc_05_after_reset");
    check_output();

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $error("[TB] FAIL scoreboard leftover observed=%0d expected=0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tt_add_sequencer.md
TT_ADD_SEQUENCER -- requirements
Module: tt_add_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge; rst_n  in  1  reset, asynchronous, active-low.
REQ-002 SHALL have ports: ena  in  1  design enable; ui_in  in  8  operand byte; uio_in  in  8  control inputs.
REQ-003 SHALL have ports: uo_out  out  8  result register; uio_out  out  8  status outputs; uio_oe  out  8  pad enables.
REQ-004 SHALL map uio_in: [0] in_valid; [2:1] op (00 ADD, 01 SUB, 10 NOT, 11 ACC); [3] res_ack; [7:4] ignored.
REQ-005 SHALL map uio_out: [4] in_ready; [5] res_valid; [6] carry; [7] busy; [3:0] constant 0.
REQ-006 SHALL drive uio_oe constant 8'hF0.

Function
REQ-007 SHALL implement FSM with states IDLE, GET_B, EXEC, RESULT.
REQ-008 IDLE: in_ready=1; on in_valid, capture A=ui_in and op; ADD/SUB -> GET_B; NOT/ACC -> EXEC.
REQ-009 GET_B: in_ready=1; on in_valid, capture B=ui_in -> EXEC; otherwise remain in GET_B; uio_in[2:1] not re-sampled.
REQ-010 EXEC: single cycle; write result to uo_out and carry flag; -> RESULT; in_ready=0.
REQ-011 RESULT: res_valid=1, in_ready=0; uo_out and carry held stable until res_ack=1, then -> IDLE.
REQ-012 One 9-bit adder SHALL be shared by all ops via operand muxes: ADD A+B; SUB A+~B+1; ACC acc+A; NOT bypasses adder (~A).
REQ-013 Result SHALL be the low 8 bits (mod 256); carry = bit 8 for ADD/ACC, 1 = no borrow for SUB, 0 for NOT.
REQ-014 ACC SHALL update an internal 8-bit accumulator to the same result; other ops SHALL leave the accumulator unchanged.
REQ-015 busy SHALL be 1 in GET_B, EXEC, RESULT; 0 in IDLE.
REQ-016 Latency: accept of last operand in cycle N -> res_valid=1 from cycle N+2.
REQ-017 in_valid while in_ready=0 SHALL be ignored; res_ack outside RESULT SHALL be ignored.
REQ-018 res_ack in the cycle RESULT is entered SHALL be honoured (RESULT lasts one cycle); IDLE then accepts input the following cycle.
REQ-019 ena=0 SHALL freeze all state, registers and outputs (no transitions, no captures).
REQ-020 uo_out SHALL retain the last result after returning to IDLE until the next EXEC.

Reset
REQ-021 rst_n=0 SHALL asynchronously force: state=IDLE, A=B=acc=0, uo_out=8'h00, carry=0, res_valid=0, busy=0.
REQ-022 After reset release, in_ready=1 (IDLE); uio_oe=8'hF0 regardless of reset.
REQ-023 Reset in any state mid-operation SHALL abandon the operation with no result emitted.

Structure
REQ-024 Shared package tt_seq_pkg SHALL hold the state enum, 2-bit opcode constants and uio bit-index constants.
REQ-025 Arithmetic SHALL live in combinational sub-module tt_alu_core (inputs: op, A, B, acc; outputs: 8-bit result, carry).
REQ-026 tt_add_sequencer SHALL contain only the FSM, operand/accumulator/result registers and pin mapping.

Verification
REQ-027 ADD 0x12 then 0x34 -> uo_out=0x46, carry=0, res_valid two cycles after second accept.
REQ-028 ADD 0xFF then 0x01 -> uo_out=0x00, carry=1; SUB 0x10 then 0x20 -> uo_out=0xF0, carry=0.
REQ-029 NOT 0xA5 -> uo_out=0x5A, carry=0, GET_B never entered.
REQ-030 ACC 0x80 -> 0x80 carry=0; ACC 0x90 -> 0x10 carry=1; ADD meanwhile leaves acc=0x10.
REQ-031 in_valid held high through RESULT with late res_ack -> no extra capture; ena=0 for 3 cycles in GET_B -> state and outputs unchanged.
REQ-032 rst_n pulsed low in GET_B -> immediate uo_out=0x00, res_valid=0, busy=0; next ACC 0x05 -> 0x05.
